mult_counter: RTL and testbench



---
 rtl/mult_counter.sv | 44 ++++
 tb/tb_mult_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_counter.sv
// Iteration counter for the sequential shift-add multiplier.
// Load arms it with N_ITER-1; it counts down to zero and holds. K flags terminal count.
module mult_counter #(
  parameter int N_ITER = 32,
  parameter int CNT_W  = 6
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Load,
  output logic K
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(N_ITER - 1);

  generate
    if (N_ITER < 1 || (N_ITER - 1) >= (1 << CNT_W)) begin : g_bad_params
      $error("mult_counter: N_ITER-1 does not fit in CNT_W bits");
    end
  endgenerate

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;

  // Load re-arms at any time; otherwise decrement and saturate at zero.
  always_comb begin
    count_d = count;
    if (Load) begin
      count_d = LOAD_VAL;
    end else if (count != '0) begin
      count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

  assign K = (count == '0);

endmodule

// File: tb/tb_mult_counter.sv
// Self-checking bench for mult_counter: expected state is pushed to a scoreboard
// queue on every driven edge and compared against the DUT one edge later.
module tb_mult_counter;

  localparam int N_ITER = 32;
  localparam int CNT_W  = 6;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             k;
    logic             rst_n;
    logic             load;
  } exp_t;

  logic Clk;
  logic Rst_n;
  logic Load;
  logic K;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   mdl_cnt = 0;
  exp_t sb_q[$];

  mult_counter #(.N_ITER(N_ITER), .CNT_W(CNT_W)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Load (Load),
    .K    (K)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard consumer: one entry per driven edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    cyc = cyc + 1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks = checks + 2;
      $display("cyc=%0d rst_n=%0b load=%0b count=%0d K=%0b exp_count=%0d exp_K=%0b",
               cyc, e.rst_n, e.load, dut.count, K, e.cnt, e.k);
      if (dut.count !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL sb_count: cyc=%0d got %0d expected %0d", cyc, dut.count, e.cnt);
      end
      if (K !== e.k) begin
        errors = errors + 1;
        $display("FAIL sb_k: cyc=%0d got %0b expected %0b", cyc, K, e.k);
      end
    end
  end

  // Drive one clock edge's inputs, push the reference result, return after the
  // scoreboard has compared that edge.
  task automatic drive(input logic rst_n, input logic load);
    exp_t e;
    @(negedge Clk);
    Rst_n = rst_n;
    Load  = load;
    if (!rst_n)             mdl_cnt = 0;
    else if (load)          mdl_cnt = N_ITER - 1;
    else if (mdl_cnt != 0)  mdl_cnt = mdl_cnt - 1;
    e.cnt   = CNT_W'(mdl_cnt);
    e.k     = (mdl_cnt == 0);
    e.rst_n = rst_n;
    e.load  = load;
    sb_q.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  task automatic run_until_k(output int edges);
    edges = 0;
    do begin
      drive(1'b1, 1'b0);
      edges = edges + 1;
    end while (K !== 1'b1 && edges < 64);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks = checks + 2;
    if (dut.count !== 6'd0) begin
      errors = errors + 1;
      $display("FAIL reset_count: got %0d expected 0", dut.count);
    end
    if (K !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reset_k: got %0b expected 1", K);
    end
    drive(1'b0, 1'b1);
    checks = checks + 1;
    if (dut.count !== 6'd0) begin
      errors = errors + 1;
      $display("FAIL reset_over_load: got %0d expected 0", dut.count);
    end
  endtask

  task automatic test_basic_count();
    int edges;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      checks = checks + 1;
      if (dut.count !== 6'd31 || K !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL load_hold: edge %0d got count=%0d K=%0b expected 31/0", i, dut.count, K);
      end
    end
    drive(1'b1, 1'b0);
    checks = checks + 1;
    if (dut.count !== 6'd30) begin
      errors = errors + 1;
      $display("FAIL first_decrement: got %0d expected 30", dut.count);
    end
    run_until_k(edges);
    checks = checks + 1;
    if (edges + 1 !== 31) begin
      errors = errors + 1;
      $display("FAIL basic_latency: got %0d edges expected 31", edges + 1);
    end
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);
    checks = checks + 1;
    if (dut.count !== 6'd0 || K !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL hold_zero: got count=%0d K=%0b expected 0/1", dut.count, K);
    end
  endtask

  task automatic test_rearm_after_done();
    int edges;
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    checks = checks + 1;
    if (dut.count !== 6'd31 || K !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rearm_load: got count=%0d K=%0b expected 31/0", dut.count, K);
    end
    run_until_k(edges);
    checks = checks + 1;
    if (edges !== 31) begin
      errors = errors + 1;
      $display("FAIL rearm_latency: got %0d edges expected 31", edges);
    end
  endtask

  task automatic test_mid_reload();
    int edges;
    drive(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0);
    checks = checks + 1;
    if (dut.count !== 6'd15) begin
      errors = errors + 1;
      $display("FAIL mid_pre: got %0d expected 15", dut.count);
    end
    drive(1'b1, 1'b1);
    checks = checks + 1;
    if (dut.count !== 6'd31 || K !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mid_reload: got count=%0d K=%0b expected 31/0", dut.count, K);
    end
    run_until_k(edges);
    checks = checks + 1;
    if (edges !== 31) begin
      errors = errors + 1;
      $display("FAIL mid_latency: got %0d edges expected 31", edges);
    end
  endtask

  task automatic test_long_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 1'b0);
      if (dut.count !== 6'd0 || K !== 1'b1) bad = bad + 1;
    end
    checks = checks + 1;
    if (bad !== 0) begin
      errors = errors + 1;
      $display("FAIL long_idle: %0d edges left zero, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_count();
    int edges;
    drive(1'b1, 1'b1);
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b0);
    checks = checks + 1;
    if (dut.count !== 6'd20) begin
      errors = errors + 1;
      $display("FAIL rst_mid_pre: got %0d expected 20", dut.count);
    end
    drive(1'b0, 1'b1);
    checks = checks + 1;
    if (dut.count !== 6'd0 || K !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL rst_mid: got count=%0d K=%0b expected 0/1", dut.count, K);
    end
    drive(1'b1, 1'b1);
    checks = checks + 1;
    if (dut.count !== 6'd31) begin
      errors = errors + 1;
      $display("FAIL rst_mid_reload: got %0d expected 31", dut.count);
    end
    run_until_k(edges);
    checks = checks + 1;
    if (edges !== 31) begin
      errors = errors + 1;
      $display("FAIL rst_mid_latency: got %0d edges expected 31", edges);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    checks = checks + 1;
    if (dut.count !== 6'd30) begin
      errors = errors + 1;
      $display("FAIL back_to_back: got %0d expected 30", dut.count);
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    Load  = 1'b0;
    test_reset();
    test_basic_count();
    test_rearm_after_done();
    test_mid_reload();
    test_long_idle();
    test_reset_mid_count();
    test_back_to_back();
    @(negedge Clk);
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      checks = checks + 1;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
